// File: rtl/ninjakun_spchr_fetch.sv
// ninjakun_spchr_fetch: fetches 4 char-ROM bytes per sprite slot and strobes the assembled 32-bit word at slot end
// Optional one-entry word cache enabled by defining NINJAKUN_SPCHR_CACHE_EN.
module ninjakun_spchr_fetch #(
   parameter int SLOT_LEN = 8
) (
   input  logic        VCLKx4,
   input  logic        RESET,
   input  logic [12:0] SPCAD,
   output logic [31:0] SPCDT,
   output logic        SPCFT,
   output logic [14:0] ROM_A,
   output logic        ROM_REQ,
   input  logic [7:0]  ROM_D,
   input  logic        ROM_ACK
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   localparam logic [3:0] LAST = 4'(SLOT_LEN - 1);
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [12:0] a_q;
   logic [1:0]  bi_q;
   logic [31:0] word_q, spcdt_q;
   logic        spcft_q, req_q;
   logic [14:0] rom_a_q;
   logic        ack, hit;
   logic [31:0] cache_word;
   assign ack     = ROM_ACK && req_q;
   assign SPCDT   = spcdt_q;
   assign SPCFT   = spcft_q;
   assign ROM_A   = rom_a_q;
   assign ROM_REQ = req_q;
`ifdef NINJAKUN_SPCHR_CACHE_EN
   logic [12:0] tag_q;
   logic [31:0] data_q;
   logic        valid_q;
   assign hit        = valid_q && SPCAD == tag_q;
   assign cache_word = data_q;
   always_ff @(posedge VCLKx4) begin
      if (RESET) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (state_q == REQ && ack && bi_q == 2'd3) begin
         valid_q <= 1'b1;
         tag_q   <= a_q;
         data_q  <= {ROM_D, word_q[23:0]};
      end
   end
`else
   assign hit        = 1'b0;
   assign cache_word = '0;
`endif
   always_ff @(posedge VCLKx4) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         bi_q    <= '0;
         word_q  <= '0;
         spcdt_q <= '0;
         spcft_q <= 1'b0;
         req_q   <= 1'b0;
         rom_a_q <= '0;
      end else begin
         spcft_q <= 1'b0;
         // the counter parks on the last slot cycle until the word is complete
         cnt_q <= (cnt_q != LAST) ? cnt_q + 4'd1 : (state_q == DONE) ? 4'd0 : cnt_q;
         case (state_q)
            IDLE: if (cnt_q == 4'd1) begin
               a_q  <= SPCAD;
               bi_q <= 2'd0;
               if (hit) begin
                  state_q <= DONE;
                  word_q  <= cache_word;
               end else begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  rom_a_q <= {SPCAD, 2'b00};
               end
            end
            REQ: if (ack) begin
               word_q[{bi_q, 3'b000} +: 8] <= ROM_D;
               if (bi_q == 2'd3) begin
                  req_q   <= 1'b0;
                  state_q <= DONE;
               end else begin
                  bi_q    <= bi_q + 2'd1;
                  rom_a_q <= {a_q, bi_q + 2'd1};
               end
            end
            DONE: if (cnt_q == LAST) begin
               spcdt_q <= word_q;
               spcft_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ninjakun_spchr_fetch.sv
// tb_ninjakun_spchr_fetch: scoreboard bench with a behavioural ROM of configurable ack latency
module tb_ninjakun_spchr_fetch;
   localparam int L = 8;
   logic        clk = 1'b0, rst = 1'b1;
   logic [12:0] spcad = 13'h0ABC;
   logic [31:0] spcdt;
   logic        spcft, rom_req;
   logic [14:0] rom_a;
   logic [7:0]  m_d = '0, inj_d = '0, rom_d;
   logic        m_ack = 1'b0, inj_ack = 1'b0, rom_ack;
   int          rom_delay = 0, w = 0, checks = 0, errors = 0;
   logic [31:0] sb[$];
   assign rom_ack = m_ack | inj_ack;
   assign rom_d   = inj_ack ? inj_d : m_d;
   always #5 clk = ~clk;
   ninjakun_spchr_fetch #(.SLOT_LEN(L)) dut (
      .VCLKx4(clk), .RESET(rst), .SPCAD(spcad), .SPCDT(spcdt), .SPCFT(spcft),
      .ROM_A(rom_a), .ROM_REQ(rom_req), .ROM_D(rom_d), .ROM_ACK(rom_ack)
   );
   function automatic logic [7:0] rom_byte(input logic [14:0] a);
      logic [3:0] n;
      n = {2'b00, a[1:0]} + 4'd1;
      return (a[14:2] == 13'h0123) ? {n, n} : (a[7:0] ^ a[14:7] ^ 8'h5A);
   endfunction
   function automatic logic [31:0] word_of(input logic [12:0] t);
      return {rom_byte({t, 2'd3}), rom_byte({t, 2'd2}), rom_byte({t, 2'd1}), rom_byte({t, 2'd0})};
   endfunction
   // ROM responder: waits rom_delay cycles per byte, then acks for one cycle
   always @(posedge clk) begin
      #1;
      if (rst || m_ack) begin
         m_ack = 1'b0;
         w = 0;
      end
      if (!rst && rom_req) begin
         if (w >= rom_delay) begin
            m_ack = 1'b1;
            m_d = rom_byte(rom_a);
         end else w++;
      end
   end
   task automatic wait_pulse(input string name, input int exp_off, input int budget);
      int off;
      logic [31:0] exp;
      off = 0;
      do begin
         @(negedge clk);
         off++;
      end while (!spcft && off < budget);
      checks++;
      if (spcft !== 1'b1 || off != exp_off) begin
         errors++;
         $display("FAIL %s_timing: pulse seen=%b at offset %0d, want offset %0d", name, spcft, off, exp_off);
      end
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      checks++;
      if (spcdt !== exp) begin
         errors++;
         $display("FAIL %s_word: spcdt=%h, want %h", name, spcdt, exp);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      spcad = 13'h0ABC;
      repeat (3) @(negedge clk);
      checks++;
      if (spcft !== 1'b0 || rom_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: spcft=%b rom_req=%b, want 0 0", spcft, rom_req);
      end
      checks++;
      if (spcdt !== 32'h0 || rom_a !== 15'h0) begin
         errors++;
         $display("FAIL reset_data: spcdt=%h rom_a=%h, want 0 0", spcdt, rom_a);
      end
      sb.push_back(word_of(13'h0ABC));
      rst = 1'b0;
      wait_pulse("reset_first", L, 4 * L);
   endtask
   task automatic test_zero_wait();
      spcad = 13'h0123;
      sb.push_back(32'h44332211);
      for (int k = 1; k < L; k++) begin
         @(negedge clk);
         if (k >= 2 && k <= 5) begin
            checks++;
            if (rom_req !== 1'b1 || rom_a !== 15'(15'h048C + k - 2)) begin
               errors++;
               $display("FAIL zero_wait_addr: cnt %0d req=%b rom_a=%h, want 1 %h", k, rom_req, rom_a, 15'(15'h048C + k - 2));
            end
         end
      end
      wait_pulse("zero_wait", 1, 3 * L);
   endtask
   task automatic test_stall();
      rom_delay = 3;
      spcad = 13'h1555;
      sb.push_back(word_of(13'h1555));
      wait_pulse("stall", 19, 40);
      rom_delay = 0;
      spcad = 13'h0321;
      sb.push_back(word_of(13'h0321));
      wait_pulse("stall_restart", L, 3 * L);
   endtask
   task automatic test_addr_toggle();
      spcad = 13'h0000;
      sb.push_back(word_of(13'h1FFF));
      for (int k = 1; k < L; k++) begin
         @(negedge clk);
         spcad = k[0] ? 13'h1FFF : 13'h0000;
         if (k >= 2 && k <= 5) begin
            checks++;
            if (rom_req !== 1'b1 || rom_a !== 15'(15'h7FFC + k - 2)) begin
               errors++;
               $display("FAIL toggle_addr: cnt %0d req=%b rom_a=%h, want 1 %h", k, rom_req, rom_a, 15'(15'h7FFC + k - 2));
            end
         end else if (k >= 6) begin
            checks++;
            if (rom_req !== 1'b0) begin
               errors++;
               $display("FAIL toggle_req_drop: cnt %0d req=%b, want 0", k, rom_req);
            end
         end
      end
      wait_pulse("toggle", 1, 3 * L);
      spcad = 13'h1FFF;
   endtask
   task automatic test_reset_mid();
      spcad = 13'h0777;
      repeat (4) @(negedge clk);
      checks++;
      if (rom_req !== 1'b1 || rom_a !== {13'h0777, 2'b10}) begin
         errors++;
         $display("FAIL mid_bi2: req=%b rom_a=%h, want 1 %h", rom_req, rom_a, {13'h0777, 2'b10});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      inj_ack = 1'b1;
      inj_d = 8'hEE;
      spcad = 13'h0888;
      checks++;
      if (rom_req !== 1'b0 || spcft !== 1'b0) begin
         errors++;
         $display("FAIL mid_req_drop: req=%b spcft=%b, want 0 0", rom_req, spcft);
      end
      checks++;
      if (rom_a !== 15'h0 || spcdt !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_data: rom_a=%h spcdt=%h, want 0 0", rom_a, spcdt);
      end
      sb.push_back(word_of(13'h0888));
      @(negedge clk);
      inj_ack = 1'b0;
      wait_pulse("after_reset", L - 1, 4 * L);
   endtask
   task automatic test_back_to_back();
      int reqs, acks, exp_n;
`ifdef NINJAKUN_SPCHR_CACHE_EN
      exp_n = 0;
`else
      exp_n = 4;
`endif
      reqs = 0;
      acks = 0;
      spcad = 13'h0456;
      sb.push_back(word_of(13'h0456));
      sb.push_back(word_of(13'h0456));
      wait_pulse("b2b_first", L, 3 * L);
      for (int k = 1; k < L; k++) begin
         @(negedge clk);
         if (rom_req) reqs++;
         if (rom_req && rom_ack) acks++;
      end
      checks++;
      if (reqs != exp_n || acks != exp_n) begin
         errors++;
         $display("FAIL b2b_requests: req cycles=%0d acks=%0d, want %0d %0d", reqs, acks, exp_n, exp_n);
      end
      wait_pulse("b2b_second", 1, 3 * L);
   endtask
   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_addr_toggle();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
